// File: rtl/udp_sample_unpacker.sv
// udp_sample_unpacker
// Reassembles a byte stream into groups of N_SAMPLES samples of SAMPLE_W bits.
// Byte k of a group lands in bits [8k+7:8k] of the packed word, and sample x[0]
// occupies the lowest SAMPLE_W bits.
// One output register holds a finished group while the next group is collected.
//
// Optional feature macro: UDP_UNPACK_ERR_CNT_EN
//   When defined, this adds err_cnt[15:0], a saturating count of short payloads.
//
// Output register states:
//   state | meaning
//   EMPTY | no group held, m_valid=0
//   FULL  | group held in m_data/m_last, m_valid=1
module udp_sample_unpacker #(
  parameter int SAMPLE_W  = 18,
  parameter int N_SAMPLES = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          s_tdata,
  input  logic                                s_tvalid,
  output logic                                s_tready,
  input  logic                                s_tlast,
  output logic [N_SAMPLES-1:0][SAMPLE_W-1:0]  m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                m_last,
  output logic                                err_short
`ifdef UDP_UNPACK_ERR_CNT_EN
  ,
  output logic [15:0]                         err_cnt
`endif
);

  localparam int WORD_W       = SAMPLE_W * N_SAMPLES;
  localparam int SAMPLE_BYTES = WORD_W / 8;
  localparam int CNT_W        = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_BYTES - 1);

  generate
    if ((WORD_W % 8) != 0) begin : g_bad_width
      $error("udp_sample_unpacker: SAMPLE_W*N_SAMPLES must be a multiple of 8");
    end
  endgenerate

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t        out_state;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] load_word;
  logic              at_last;
  logic              accept;
  logic              load;
  logic              short_end;

  // Handshake decode; the final byte of a group is held off only while the
  // output register is occupied and not being drained this cycle.
  always_comb begin
    at_last   = (cnt == LAST_IDX);
    s_tready  = !(at_last && (out_state == FULL) && !m_ready);
    accept    = s_tvalid && s_tready;
    load      = accept && at_last;
    short_end = accept && s_tlast && !at_last;
    load_word = acc;
    load_word[WORD_W-8 +: 8] = s_tdata;
  end

  assign m_valid = (out_state == FULL);

  // Byte collection, output register state and the short-payload pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      out_state <= EMPTY;
      m_data    <= '0;
      m_last    <= 1'b0;
      err_short <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < SAMPLE_BYTES; k++) begin
          if (cnt == CNT_W'(k)) begin
            acc[k*8 +: 8] <= s_tdata;
          end
        end
        // A tlast before the final byte discards the partial group.
        if (at_last || s_tlast) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      err_short <= short_end;
      // A load wins over a drain, so load-with-ready stays FULL with new data.
      if (load) begin
        out_state <= FULL;
        m_data    <= load_word;
        m_last    <= s_tlast;
      end else if (m_ready) begin
        out_state <= EMPTY;
      end
    end
  end

`ifdef UDP_UNPACK_ERR_CNT_EN
  // Saturating count of short payloads.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (short_end && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_sample_unpacker.sv
// Testbench for udp_sample_unpacker (default parameters: 18-bit samples, 4 per group, 9 bytes).
module tb_udp_sample_unpacker;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [3:0][17:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              err_short;
`ifdef UDP_UNPACK_ERR_CNT_EN
  logic [15:0]       err_cnt;
`endif

  always #5 clk = ~clk;

  udp_sample_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .err_short (err_short)
`ifdef UDP_UNPACK_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the group in progress, and groups produced but not yet consumed.
  typedef struct packed {
    logic [71:0] w;
    logic        l;
  } grp_t;

  logic [7:0] grp[$];
  grp_t       outq[$];
  logic       err_exp = 1'b0;
  int         groups_out = 0;
  logic       mv_s, ml_s, es_s, rdy_s;

  // One clock: drive inputs, compare outputs at the falling edge, then advance the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic r, input logic rs, output logic acc);
    logic        exp_rdy;
    logic [71:0] w;
    s_tvalid = v; s_tdata = d; s_tlast = l; m_ready = r; rst = rs;
    @(negedge clk);
    exp_rdy = !(grp.size() == 8 && outq.size() > 0 && !r);
    mv_s = m_valid; ml_s = m_last; es_s = err_short; rdy_s = s_tready;
    check("s_tready", s_tready, exp_rdy);
    check("m_valid", m_valid, outq.size() > 0);
    check("err_short", err_short, err_exp);
    if (outq.size() > 0) begin
      check("m_data", m_data, outq[0].w);
      check("m_last", m_last, outq[0].l);
    end
    acc = v && exp_rdy && !rs;
    if (rs) begin
      grp.delete();
      outq.delete();
      err_exp = 1'b0;
    end else begin
      if (outq.size() > 0 && r) begin
        void'(outq.pop_front());
        groups_out++;
      end
      err_exp = 1'b0;
      if (acc) begin
        grp.push_back(d);
        if (grp.size() == 9) begin
          w = '0;
          foreach (grp[k]) w = w | (72'(grp[k]) << (8 * k));
          outq.push_back('{w: w, l: l});
          grp.delete();
        end else if (l) begin
          grp.delete();
          err_exp = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [71:0]      bytes;
    logic             tlast;
    logic [3:0][17:0] exp;
    logic             exp_last;
  } vec_t;

  vec_t tbl[5];

  // Feed one table group back-to-back with m_ready=1 and check it against hand-derived samples.
  task automatic run_vec(input int i);
    logic a;
    for (int k = 0; k < 9; k++)
      cycle(1'b1, tbl[i].bytes[8*k +: 8], tbl[i].tlast && (k == 8), 1'b1, 1'b0, a);
    check($sformatf("vec%0d m_valid", i), m_valid, 1'b1);
    check($sformatf("vec%0d m_data", i), m_data, tbl[i].exp);
    check($sformatf("vec%0d m_last", i), m_last, tbl[i].exp_last);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int   idx[$];
    logic lst[$];
    int   sent, first_drop, bad_drop, g0, pulses, mv_cnt;

    tbl[0] = '{bytes: 72'h00_00_0F_FF_F0_00_00_FF_FF, tlast: 1'b0,
               exp: {18'h00000, 18'h0FFFF, 18'h00000, 18'h0FFFF}, exp_last: 1'b0};
    tbl[1] = '{bytes: {9{8'hFF}}, tlast: 1'b1,
               exp: {4{18'h3FFFF}}, exp_last: 1'b1};
    tbl[2] = '{bytes: 72'h80_00_00_00_10_00_04_00_01, tlast: 1'b0,
               exp: {18'h20000, 18'h00001, 18'h00001, 18'h00001}, exp_last: 1'b0};
    tbl[3] = '{bytes: 72'h0, tlast: 1'b1, exp: '0, exp_last: 1'b1};
    tbl[4] = '{bytes: 72'h00_00_C0_00_00_00_0C_00_00, tlast: 1'b0,
               exp: {18'h00003, 18'h00000, 18'h00003, 18'h00000}, exp_last: 1'b0};

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset s_tready", s_tready, 1'b1);
    check("reset m_valid", m_valid, 1'b0);
    check("reset m_last", m_last, 1'b0);
    check("reset err_short", err_short, 1'b0);
    check("reset m_data", m_data, 72'h0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Two back-to-back groups of 0xFF with tlast on byte 18.
    for (int i = 0; i < 19; i++) begin
      cycle(i < 18, 8'hFF, i == 17, 1'b1, 1'b0, a);
      if (mv_s) begin
        idx.push_back(i);
        lst.push_back(ml_s);
      end
    end
    check("two-group count", idx.size(), 2);
    if (idx.size() == 2) begin
      check("two-group spacing", idx[1] - idx[0], 9);
      check("two-group first m_last", lst[0], 1'b0);
      check("two-group second m_last", lst[1], 1'b1);
    end

    // Backpressure: m_ready low for 20 cycles under a continuous 27-byte stream.
    sent = 0; first_drop = -1; bad_drop = 0; g0 = groups_out;
    for (int c = 0; c < 200; c++) begin
      if (sent == 27 && outq.size() == 0 && grp.size() == 0) break;
      cycle(sent < 27, 8'(sent * 7 + 3), 1'b0, c >= 20, 1'b0, a);
      if (sent < 27 && !rdy_s) begin
        if (first_drop < 0) first_drop = sent;
        if (sent != 17) bad_drop++;
      end
      if (a) sent++;
    end
    check("bp first stall byte", first_drop, 17);
    check("bp stalls elsewhere", bad_drop, 0);
    check("bp bytes sent", sent, 27);
    check("bp groups out", groups_out - g0, 3);

    // Short payload: tlast on byte 5 of a group.
    pulses = 0; mv_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      cycle(k < 5, 8'(k + 8'h40), k == 4, 1'b1, 1'b0, a);
      if (es_s) pulses++;
      if (mv_s) mv_cnt++;
    end
    check("short err pulses", pulses, 1);
    check("short no m_valid", mv_cnt, 0);
    run_vec(2);

    // Reset with the output full and a partial group collected.
    for (int k = 0; k < 9; k++) cycle(1'b1, 8'hA5, k == 8, 1'b0, 1'b0, a);
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, a);
    check("rst s_tready", s_tready, 1'b1);
    check("rst m_valid", m_valid, 1'b0);
    check("rst m_last", m_last, 1'b0);
    check("rst err_short", err_short, 1'b0);
    check("rst m_data", m_data, 72'h0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
    check("rst no late err_short", es_s, 1'b0);
    run_vec(0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 499) == 0, a);
    end

`ifdef UDP_UNPACK_ERR_CNT_EN
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
    for (int j = 0; j < 3; j++) begin
      cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, a);
      cycle(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, a);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
    check("err_cnt three shorts", err_cnt, 16'd3);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
    check("err_cnt after rst", err_cnt, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_sample_unpacker.md
# udp_sample_unpacker

Receive-side counterpart of the sample packer in the UDP packetizer path. It accepts a byte stream from the UDP receive datapath and reassembles each group of SAMPLE_BYTES bytes into N_SAMPLES samples of SAMPLE_W bits. It sits between the UDP payload extractor and the sample consumers (DAC/loopback logic). It buffers one complete group while the next group is being collected, with ready/valid flow control on both sides.

## Interface
- SAMPLE_W, 18, bits per sample
- N_SAMPLES, 4, samples per group
- SAMPLE_BYTES, derived = SAMPLE_W*N_SAMPLES/8 (9 by default); elaboration error if SAMPLE_W*N_SAMPLES is not a multiple of 8
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_tdata  input  8  payload byte
- s_tvalid  input  1  byte valid
- s_tready  output  1  byte accepted when s_tvalid && s_tready
- s_tlast  input  1  final byte of UDP payload
- m_data  output  [N_SAMPLES-1:0][SAMPLE_W-1:0]  reassembled samples
- m_valid  output  1  m_data valid
- m_ready  input  1  consumer accepts when m_valid && m_ready
- m_last  output  1  group ended a payload (its final byte carried s_tlast)
- err_short  output  1  one-cycle pulse: payload ended mid-group

## Operation
- Packed word W = {x[N-1],...,x[1],x[0]}, with x[0] in W[SAMPLE_W-1:0]. Byte k of a group (k=0 first on the wire) carries W[8k+7:8k]. This is the inverse of the transmit packer.
- Byte counter cnt, 0..SAMPLE_BYTES-1, plus an accumulator register.
  - Each accepted byte is written into accumulator slot cnt, and cnt increments.
  - On the byte with cnt==SAMPLE_BYTES-1: the full word loads into the output register, m_valid is set, m_last is set to s_tlast, and cnt wraps to 0.
- Output register states:
  - EMPTY (m_valid=0).
  - FULL (m_valid=1). FULL→EMPTY on m_ready with no simultaneous load. A load in the same cycle as m_ready keeps the state FULL with the new data.
- Backpressure: s_tready = !(cnt==SAMPLE_BYTES-1 && m_valid && !m_ready). Bytes 0..SAMPLE_BYTES-2 of the next group are always accepted while the output is held.
- Short payload: an accepted byte with s_tlast=1 and cnt!=SAMPLE_BYTES-1 causes:
  - the partial group is discarded and cnt resets to 0;
  - err_short pulses the following cycle;
  - no m_valid is produced for that partial group;
  - the output register is untouched.
- s_tlast on a non-final byte of a group never sets m_last.
- Idle cycles (s_tvalid=0) inside a group are allowed and leave cnt unchanged.

## Timing
- Reset values: s_tready=1, m_valid=0, m_last=0, err_short=0, m_data=0, cnt=0, accumulator=0.
- Latency: m_valid rises on the clock edge that accepts the last byte of a group, so it is visible the cycle after that byte.
- Throughput: one group per SAMPLE_BYTES cycles, sustained, when m_ready=1.
- m_data and m_last hold stable while m_valid && !m_ready.
- rst mid-group or with the output FULL: all state clears at that edge; the partial group and held output are lost, and no err_short pulse is produced.
- s_tready depends combinationally on m_ready; there are no other combinational input-to-output paths.

## Configuration
- UDP_UNPACK_ERR_CNT_EN:
  - Defined: adds output err_cnt [15:0], a saturating count of err_short events, reset to 0. It holds at 16'hFFFF once reached.
  - Undefined: the port and counter are absent; err_short is still present.

## Test plan
- Reset, then feed bytes FF,FF,00,00,F0,FF,0F,00,00 back-to-back with m_ready=1 → one m_valid cycle with x[0]=18'h0FFFF, x[1]=0, x[2]=18'h0FFFF, x[3]=0, and m_last=0.
- 18 bytes of 0xFF with s_tlast on byte 18 and m_ready=1 → two groups, each sample 18'h3FFFF, on consecutive 9-cycle periods; m_last=0 on the first group and 1 on the second.
- m_ready=0 for the first 20 cycles with a continuous stream of 27 bytes → first group holds stable; s_tready drops only at byte 18. After m_ready rises, all three groups emerge in order and no byte is lost.
- s_tlast on byte 5 of a group → err_short pulses once and no m_valid. The next 9 bytes form a correct group starting at byte index 0.
- Assert rst after 4 bytes of a group → all outputs return to reset values. The next 9 bytes form a clean group.
- With UDP_UNPACK_ERR_CNT_EN defined, three short payloads → err_cnt=3; after rst, err_cnt=0.
